button_debounce_pulse: RTL and testbench
========================================

BUTTON_DEBOUNCE_PULSE -- requirements
Module: button_debounce_pulse

Interface
REQ-001 Parameter TICK_DIV, default 100_000, is the number of CLK100MHZ cycles per sample tick (1 ms).
REQ-002 Parameter DEBOUNCE_TICKS, default 20, is the number of consecutive agreeing samples required to accept a level change.
REQ-003 Parameter REPEAT_DELAY_TICKS, default 500, is the number of held ticks before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD_TICKS, default 100, is the number of ticks between subsequent auto-repeat pulses.
REQ-005 The block SHALL have exactly one clock and one reset: CLK100MHZ (input, 1 bit, sole clock); reset is asynchronous and active-low.
REQ-006 CPU_RESETN is a 1-bit input: asynchronous, active-low reset.
REQ-007 button_in is a 1-bit input: raw, asynchronous, bouncing push-button level.
REQ-008 repeat_en is a 1-bit input: when 1, auto-repeat is enabled while the button is held.
REQ-009 press_pulse is a 1-bit output: single-CLK100MHZ-cycle pulse per accepted press or auto-repeat.
REQ-010 release_pulse is a 1-bit output: single-cycle pulse per accepted release.
REQ-011 button_level is a 1-bit output: debounced button level.

Function
REQ-012 button_in SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-013 A tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is high for one cycle when the count equals TICK_DIV-1; no derived clocks.
REQ-014 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; the FSM SHALL sample and change state only on tick cycles.
REQ-015 IDLE: sample 1 -> PRESS_WAIT with the debounce count set to 1; sample 0 -> stay.
REQ-016 PRESS_WAIT: sample 1 increments the count; reaching DEBOUNCE_TICKS -> HELD; sample 0 -> IDLE with the count cleared.
REQ-017 On the IDLE/PRESS_WAIT->HELD transition, press_pulse SHALL be 1 in the following cycle only, and button_level SHALL become 1.
REQ-018 HELD: sample 0 -> RELEASE_WAIT with the count set to 1; the repeat counter SHALL increment on each tick.
REQ-019 RELEASE_WAIT: sample 0 increments the count; reaching DEBOUNCE_TICKS -> IDLE, with button_level set to 0 and release_pulse for one cycle.
REQ-020 RELEASE_WAIT: sample 1 -> HELD with no pulse; the repeat counter holds its value in RELEASE_WAIT.
REQ-021 Auto-repeat with repeat_en=1 in HELD SHALL pulse when the repeat count reaches REPEAT_DELAY_TICKS, then every REPEAT_PERIOD_TICKS.
REQ-022 The repeat counter SHALL clear on entry to HELD from PRESS_WAIT and SHALL saturate rather than wrap.
REQ-023 When repeat_en=0, no repeat pulses SHALL occur, and the repeat counter keeps running.
REQ-024 Toggling repeat_en mid-hold takes effect at the next tick.
REQ-025 press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-026 Pulses SHALL be separated by at least TICK_DIV cycles.
REQ-027 Counter widths SHALL be derived with $clog2 from the parameters; no overflow for the default values.

Reset
REQ-028 On CPU_RESETN=0, the following SHALL clear asynchronously: FSM to IDLE, synchronizer flops, tick, debounce and repeat counters, press_pulse=0, release_pulse=0, button_level=0.
REQ-029 Reset deassertion mid-press SHALL require a full fresh debounce before any pulse.
REQ-030 Reset asserted during a press_pulse cycle SHALL truncate the pulse.

Structure
REQ-031 FSM state encodings and default timing constants SHALL live in the shared board package/include btn_pkg.
REQ-032 The tick counter SHALL be a sub-module tick_gen (parameter DIV; ports CLK100MHZ, CPU_RESETN, tick), reusable as a clock-enable replacement for the team's clock dividers.
REQ-033 The output press_pulse SHALL feed count_button_push as a clock-enable in the CLK100MHZ domain.

Verification (bench params: TICK_DIV=10, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_PERIOD_TICKS=2)
REQ-034 Clean press held 200 cycles, repeat_en=0 -> exactly one press_pulse, 22..33 cycles after the edge; one release_pulse 22..33 cycles after release.
REQ-035 Bounce 0/1 toggling every 7 cycles for 60 cycles, then steady 1 -> exactly one press_pulse, after the steady level.
REQ-036 Glitch high for 15 cycles -> no pulses; button_level stays 0.
REQ-037 repeat_en=1, hold 150 cycles -> first pulse, repeat at +50 cycles, then every 20 cycles until the release debounce.
REQ-038 Release bounce of 1 tick of 0 during HELD -> no release_pulse and no extra press_pulse; button_level stays 1.
REQ-039 CPU_RESETN asserted mid-PRESS_WAIT, then released with the button still held -> outputs 0 during reset; press_pulse only after 3 further ticks.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared board package for push-button handling: FSM state encoding,
// default timing constants and a counter-width helper.
package btn_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_e;

   // Default timing for a 100 MHz board clock with a 1 ms sample tick
   localparam int unsigned DEF_TICK_DIV            = 100_000;
   localparam int unsigned DEF_DEBOUNCE_TICKS      = 20;
   localparam int unsigned DEF_REPEAT_DELAY_TICKS  = 500;
   localparam int unsigned DEF_REPEAT_PERIOD_TICKS = 100;

   // Bits needed to hold values 0..maxval (never less than one bit)
   function automatic int unsigned cnt_width(input int unsigned maxval);
      return (maxval < 2) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle clock-enable every DIV cycles.
// Used in place of derived clocks so everything stays on CLK100MHZ.
module tick_gen
   import btn_pkg::*;
#(
   parameter int unsigned DIV = DEF_TICK_DIV
) (
   input  logic CLK100MHZ,
   input  logic CPU_RESETN,
   output logic tick
);

   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: 0..DIV-1 then wrap
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   // Count register, cleared by the board reset
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) cnt_q <= '0;
      else             cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronizes the raw button, debounces it on a
// slow sample tick and emits single-cycle press/release pulses plus an
// optional auto-repeat. press_pulse is intended as a clock-enable for
// downstream counters in the CLK100MHZ domain.
module button_debounce_pulse
   import btn_pkg::*;
#(
   parameter int unsigned TICK_DIV            = DEF_TICK_DIV,
   parameter int unsigned DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
   parameter int unsigned REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
   parameter int unsigned REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
   input  logic CLK100MHZ,
   input  logic CPU_RESETN,
   input  logic button_in,
   input  logic repeat_en,
   output logic press_pulse,
   output logic release_pulse,
   output logic button_level
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_TICKS);
   localparam int unsigned RW = cnt_width(REPEAT_DELAY_TICKS);
   localparam int unsigned PW = cnt_width(REPEAT_PERIOD_TICKS);

   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_TICKS);
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_DELAY_TICKS);
   localparam logic [PW-1:0] PER_MAX = PW'(REPEAT_PERIOD_TICKS);
   // A single agreeing sample is enough: skip the wait states entirely
   localparam bit DEB_ONE = (DEBOUNCE_TICKS <= 1);

   logic          tick;
   logic          sync1_q, sync2_q;
   btn_state_e    state_q, state_d;
   logic [DW-1:0] deb_q, deb_d, deb_inc;
   logic [RW-1:0] rep_q, rep_d, rep_inc;
   logic [PW-1:0] per_q, per_d, per_inc;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          level_q, level_d;
   logic          accept, fire;

   tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick_gen (
      .CLK100MHZ (CLK100MHZ),
      .CPU_RESETN(CPU_RESETN),
      .tick      (tick)
   );

   assign deb_inc = deb_q + 1'b1;
   assign rep_inc = rep_q + 1'b1;
   assign per_inc = per_q + 1'b1;

   // Two-flop synchronizer for the asynchronous button level
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= button_in;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic: the FSM only looks at the button on tick cycles
   always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      rep_d     = rep_q;
      per_d     = per_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      level_d   = level_q;
      accept    = 1'b0;
      fire      = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (sync2_q) begin
                  if (DEB_ONE) begin
                     accept = 1'b1;
                  end else begin
                     state_d = ST_PRESS_WAIT;
                     deb_d   = DW'(1);
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (sync2_q) begin
                  if (deb_inc >= DEB_MAX) accept = 1'b1;
                  else                    deb_d  = deb_inc;
               end else begin
                  state_d = ST_IDLE;
                  deb_d   = '0;
               end
            end
            ST_HELD: begin
               if (!sync2_q) begin
                  if (DEB_ONE) begin
                     state_d   = ST_IDLE;
                     level_d   = 1'b0;
                     release_d = 1'b1;
                  end else begin
                     state_d = ST_RELEASE_WAIT;
                     deb_d   = DW'(1);
                  end
               end else if (rep_q != REP_MAX) begin
                  // Initial delay: counter saturates at the delay value
                  rep_d = rep_inc;
                  fire  = (rep_inc == REP_MAX);
               end else if (per_inc >= PER_MAX) begin
                  // Past the delay, a phase counter spaces the repeats
                  per_d = '0;
                  fire  = 1'b1;
               end else begin
                  per_d = per_inc;
               end
            end
            ST_RELEASE_WAIT: begin
               // Repeat counters hold here so a short dropout is seamless
               if (!sync2_q) begin
                  if (deb_inc >= DEB_MAX) begin
                     state_d   = ST_IDLE;
                     deb_d     = '0;
                     level_d   = 1'b0;
                     release_d = 1'b1;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  state_d = ST_HELD;
                  deb_d   = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (accept) begin
         state_d = ST_HELD;
         deb_d   = '0;
         rep_d   = '0;
         per_d   = '0;
         press_d = 1'b1;
         level_d = 1'b1;
      end
      if (fire && repeat_en) press_d = 1'b1;
   end

   // State, counters and registered outputs; reset truncates any pulse
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q   <= ST_IDLE;
         deb_q     <= '0;
         rep_q     <= '0;
         per_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_q     <= deb_d;
         rep_q     <= rep_d;
         per_q     <= per_d;
         press_q   <= press_d;
         release_q <= release_d;
         level_q   <= level_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign button_level  = level_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Scoreboard bench for button_debounce_pulse with a small tick divider.
// Stimulus pushes expected pulses (kind + cycle window) into a queue; the
// monitor pops one entry for every pulse the DUT produces.
module tb_button_debounce_pulse;

   localparam int TD = 10;
   localparam int DB = 3;
   localparam int RD = 5;
   localparam int RP = 2;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic button_in = 1'b0;
   logic repeat_en = 1'b0;
   logic press_pulse;
   logic release_pulse;
   logic button_level;

   always #5 clk = ~clk;

   button_debounce_pulse #(
      .TICK_DIV           (TD),
      .DEBOUNCE_TICKS     (DB),
      .REPEAT_DELAY_TICKS (RD),
      .REPEAT_PERIOD_TICKS(RP)
   ) dut (
      .CLK100MHZ    (clk),
      .CPU_RESETN   (rst_n),
      .button_in    (button_in),
      .repeat_en    (repeat_en),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .button_level (button_level)
   );

   // Cycle count since reset release; sample edges are multiples of TD
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      bit is_press;
      int lo;
      int hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
   endtask

   task automatic expect_pulse(input bit is_press, input int lo, input int hi);
      exp_t e;
      e.is_press = is_press;
      e.lo       = lo;
      e.hi       = hi;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Land just after a sample edge so pulse timing is deterministic
   task automatic align();
      do begin
         @(posedge clk);
         #1;
      end while (cyc % TD != 0);
   endtask

   task automatic drain(input string name);
      check(exp_q.size() == 0, {name, "_missing_pulses"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: every pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && (press_pulse || release_pulse)) begin
         $display("cyc %0d: press=%0b release=%0b level=%0b", cyc, press_pulse, release_pulse, button_level);
         check(!(press_pulse && release_pulse), "pulse_exclusive", 1, 0);
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_pulse", cyc, -1);
         end else begin
            mon_e = exp_q.pop_front();
            check(press_pulse == mon_e.is_press, "pulse_kind_press", press_pulse, mon_e.is_press);
            check(cyc >= mon_e.lo && cyc <= mon_e.hi, "pulse_time_lo", cyc, mon_e.lo);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   int e;

   initial begin
      // Reset state
      wait_cyc(3);
      check(press_pulse == 1'b0, "reset_press", press_pulse, 0);
      check(release_pulse == 1'b0, "reset_release", release_pulse, 0);
      check(button_level == 1'b0, "reset_level", button_level, 0);
      @(negedge clk) rst_n = 1'b1;

      // Clean press held 200 cycles, no repeat
      align();
      e = cyc;
      expect_pulse(1'b1, e + 22, e + 33);
      button_in = 1'b1;
      wait_cyc(100);
      check(button_level == 1'b1, "clean_level_held", button_level, 1);
      wait_cyc(100);
      expect_pulse(1'b0, cyc + 22, cyc + 33);
      button_in = 1'b0;
      wait_cyc(60);
      check(button_level == 1'b0, "clean_level_released", button_level, 0);
      drain("clean");

      // Bounce every 7 cycles for 60 cycles, then steady high
      align();
      e = cyc;
      expect_pulse(1'b1, e + 60, e + 93);
      for (int i = 0; i < 60; i++) begin
         button_in = ((i / 7) % 2 == 0);
         wait_cyc(1);
      end
      button_in = 1'b1;
      wait_cyc(100);
      check(button_level == 1'b1, "bounce_level_held", button_level, 1);
      expect_pulse(1'b0, cyc + 22, cyc + 33);
      button_in = 1'b0;
      wait_cyc(60);
      drain("bounce");

      // 15-cycle glitch: rejected
      align();
      button_in = 1'b1;
      wait_cyc(15);
      check(button_level == 1'b0, "glitch_level_during", button_level, 0);
      button_in = 1'b0;
      wait_cyc(60);
      check(button_level == 1'b0, "glitch_level_after", button_level, 0);
      drain("glitch");

      // Auto-repeat: press at +30, repeats +50 then every +20
      repeat_en = 1'b1;
      align();
      e = cyc;
      expect_pulse(1'b1, e + 30, e + 30);
      expect_pulse(1'b1, e + 80, e + 80);
      expect_pulse(1'b1, e + 100, e + 100);
      expect_pulse(1'b1, e + 120, e + 120);
      expect_pulse(1'b1, e + 140, e + 140);
      button_in = 1'b1;
      wait_cyc(150);
      expect_pulse(1'b0, e + 180, e + 180);
      button_in = 1'b0;
      wait_cyc(60);
      drain("repeat");
      repeat_en = 1'b0;

      // One tick of release bounce while held
      align();
      e = cyc;
      expect_pulse(1'b1, e + 22, e + 33);
      button_in = 1'b1;
      wait_cyc(45);
      button_in = 1'b0;
      wait_cyc(10);
      button_in = 1'b1;
      wait_cyc(10);
      check(button_level == 1'b1, "dropout_level", button_level, 1);
      wait_cyc(35);
      expect_pulse(1'b0, cyc + 22, cyc + 33);
      button_in = 1'b0;
      wait_cyc(60);
      drain("dropout");

      // Reset mid-debounce with the button still held
      align();
      button_in = 1'b1;
      wait_cyc(25);
      rst_n = 1'b0;
      #1;
      check(press_pulse == 1'b0, "rst_mid_press", press_pulse, 0);
      check(release_pulse == 1'b0, "rst_mid_release", release_pulse, 0);
      check(button_level == 1'b0, "rst_mid_level", button_level, 0);
      wait_cyc(5);
      check(button_level == 1'b0, "rst_hold_level", button_level, 0);
      @(negedge clk) rst_n = 1'b1;
      expect_pulse(1'b1, 3 * TD, 3 * TD);
      wait_cyc(50);
      check(button_level == 1'b1, "rst_after_level", button_level, 1);
      expect_pulse(1'b0, cyc + 22, cyc + 33);
      button_in = 1'b0;
      wait_cyc(60);
      drain("reset_mid");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
